// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback unit.
package wb_pkg;

   localparam int XLEN_DEF = 32;
   localparam int REG_AW   = 5;

   // One buffered writeback result: destination register plus data.
   typedef struct packed {
      logic [REG_AW-1:0]   rd;
      logic [XLEN_DEF-1:0] data;
   } wb_entry_t;

endpackage : wb_pkg

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries (pointer-plus-count).
// The caller guarantees no push when full and no pop when empty.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  wb_entry_t push_data,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   wb_entry_t       mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;

   // Pointer and occupancy bookkeeping.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage.
   // NOTE: the data array is deliberately not reset; validity is tracked by
   // count alone, and leaving it unreset lets it map onto plain storage.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule : wb_fifo

// File: rtl/regfile_wb.sv
// Register-file writeback unit: LSU-priority arbitration between LSU and
// buffered ALU results, a registered single write port, and a pending-write
// scoreboard for RAW hazard detection.
module regfile_wb
   import wb_pkg::*;
#(
   parameter int XLEN           = XLEN_DEF,
   parameter int NREG           = 32,
   parameter int ALU_FIFO_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iss_en,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   output logic              alu_ready,
   input  logic              lsu_valid,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              lsu_ready,
   output logic              rd_en,
   output logic [REG_AW-1:0] rd_addr,
   output logic [XLEN-1:0]   rd_data,
   output logic [NREG-1:0]   busy
);

   logic      fifo_full;
   logic      fifo_empty;
   logic      fifo_push;
   logic      fifo_pop;
   wb_entry_t fifo_in;
   wb_entry_t fifo_head;
   logic [NREG-1:0] busy_next;

   // ALU results always go through the buffer; the LSU wins the write port.
   assign lsu_ready = 1'b1;
   assign alu_ready = !fifo_full;
   assign fifo_push = alu_valid && alu_ready;
   assign fifo_pop  = !lsu_valid && !fifo_empty;
   assign fifo_in   = '{rd: alu_rd, data: alu_data};

   wb_fifo #(
      .DEPTH (ALU_FIFO_DEPTH)
   ) u_alu_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   // Output write register: LSU first, then FIFO head, else idle.
   // Writes to x0 are consumed but never enable the register file.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
         rd_data <= '0;
      end else if (lsu_valid) begin
         rd_en   <= (lsu_rd != '0);
         rd_addr <= lsu_rd;
         rd_data <= lsu_data;
      end else if (!fifo_empty) begin
         rd_en   <= (fifo_head.rd != '0);
         rd_addr <= fifo_head.rd;
         rd_data <= fifo_head.data;
      end else begin
         rd_en   <= 1'b0;
      end
   end

   // Scoreboard update: clear on completed write, then set on issue so a
   // same-index collision leaves the bit set; x0 is never busy.
   // NOTE: busy_next starts from a full default so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      busy_next = busy;
      if (rd_en) busy_next[rd_addr] = 1'b0;
      if (iss_en && (iss_rd != '0)) busy_next[iss_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (!rst) busy <= '0;
      else      busy <= busy_next;
   end

   assign rs1_busy = busy[rs1_addr];
   assign rs2_busy = busy[rs2_addr];

endmodule : regfile_wb

// File: tb/tb_regfile_wb.sv
// Directed, table-driven bench for regfile_wb: each row is applied for one
// clock and the registered outputs are compared just after that edge.
module tb_regfile_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_en;
   logic [4:0]  iss_rd;
   logic [4:0]  rs1_addr, rs2_addr;
   logic        rs1_busy, rs2_busy;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        lsu_valid;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        lsu_ready;
   logic        rd_en;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] busy;

   int total = 0;
   int bad   = 0;

   regfile_wb #(
      .XLEN           (32),
      .NREG           (32),
      .ALU_FIFO_DEPTH (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .iss_en    (iss_en),
      .iss_rd    (iss_rd),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .rs1_busy  (rs1_busy),
      .rs2_busy  (rs2_busy),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .lsu_valid (lsu_valid),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .lsu_ready (lsu_ready),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        iss_en;
      logic [4:0]  iss_rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        alu_v;
      logic [4:0]  alu_rd;
      logic [31:0] alu_d;
      logic        lsu_v;
      logic [4:0]  lsu_rd;
      logic [31:0] lsu_d;
      logic        e_en;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      logic        e_ready;
      logic        e_rs1;
      logic        e_rs2;
      logic [31:0] e_busy;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst       = v.rst;
      iss_en    = v.iss_en;
      iss_rd    = v.iss_rd;
      rs1_addr  = v.rs1;
      rs2_addr  = v.rs2;
      alu_valid = v.alu_v;
      alu_rd    = v.alu_rd;
      alu_data  = v.alu_d;
      lsu_valid = v.lsu_v;
      lsu_rd    = v.lsu_rd;
      lsu_data  = v.lsu_d;
   endtask

   task automatic idle();
      rst = 1'b1; iss_en = 1'b0; iss_rd = '0; rs1_addr = '0; rs2_addr = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
   endtask

   initial begin
      // Field order: rst iss_en iss_rd rs1 rs2 | alu_v alu_rd alu_d | lsu_v lsu_rd lsu_d |
      //              e_en e_addr e_data e_ready e_rs1 e_rs2 e_busy
      // Reset held two edges with every input active, then released idle.
      vecs[0]  = '{0,1,5,5,0, 1,1,32'h1,        1,2,32'h2,   0,0,0,1,0,0,32'h0};
      vecs[1]  = '{0,1,5,5,0, 1,1,32'h1,        1,2,32'h2,   0,0,0,1,0,0,32'h0};
      vecs[2]  = '{1,0,0,5,0, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,0,0,32'h0};
      vecs[3]  = '{1,0,0,5,0, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,0,0,32'h0};
      // ALU single: issue x5, ALU result pushed, written one edge later.
      vecs[4]  = '{1,1,5,5,0, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,1,0,32'h20};
      vecs[5]  = '{1,0,0,5,0, 1,5,32'hDEADBEEF, 0,0,32'h0,   0,0,0,1,1,0,32'h20};
      vecs[6]  = '{1,0,0,5,0, 0,0,32'h0,        0,0,32'h0,   1,5,32'hDEADBEEF,1,1,0,32'h20};
      vecs[7]  = '{1,0,0,5,0, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,0,0,32'h0};
      // Conflict: LSU x3 wins, ALU x4 follows.
      vecs[8]  = '{1,0,0,0,0, 1,4,32'h22,       1,3,32'h11,  1,3,32'h11,1,0,0,32'h0};
      vecs[9]  = '{1,0,0,0,0, 0,0,32'h0,        0,0,32'h0,   1,4,32'h22,1,0,0,32'h0};
      vecs[10] = '{1,0,0,0,0, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,0,0,32'h0};
      // Backpressure: four LSU cycles, ALU pushes x6, x7; x8 offered while full.
      vecs[11] = '{1,0,0,0,0, 1,6,32'h66,       1,10,32'hA0, 1,10,32'hA0,1,0,0,32'h0};
      vecs[12] = '{1,0,0,0,0, 1,7,32'h77,       1,11,32'hA1, 1,11,32'hA1,0,0,0,32'h0};
      vecs[13] = '{1,0,0,0,0, 1,8,32'h88,       1,12,32'hA2, 1,12,32'hA2,0,0,0,32'h0};
      vecs[14] = '{1,0,0,0,0, 0,0,32'h0,        1,13,32'hA3, 1,13,32'hA3,0,0,0,32'h0};
      vecs[15] = '{1,0,0,0,0, 0,0,32'h0,        0,0,32'h0,   1,6,32'h66,1,0,0,32'h0};
      vecs[16] = '{1,0,0,0,0, 0,0,32'h0,        0,0,32'h0,   1,7,32'h77,1,0,0,32'h0};
      vecs[17] = '{1,0,0,0,0, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,0,0,32'h0};
      // x0: ALU result to x0 yields no write; issuing x0 never marks busy.
      vecs[18] = '{1,0,0,0,0, 1,0,32'h99,       0,0,32'h0,   0,0,0,1,0,0,32'h0};
      vecs[19] = '{1,1,0,0,0, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,0,0,32'h0};
      vecs[20] = '{1,0,0,0,0, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,0,0,32'h0};
      // Same-edge hazard on x9: re-issue as the write completes keeps it busy.
      vecs[21] = '{1,1,9,9,9, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,1,1,32'h200};
      vecs[22] = '{1,0,0,9,9, 0,0,32'h0,        1,9,32'h9,   1,9,32'h9,1,1,1,32'h200};
      vecs[23] = '{1,1,9,9,9, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,1,1,32'h200};
      vecs[24] = '{1,0,0,9,9, 0,0,32'h0,        1,9,32'h5,   1,9,32'h5,1,1,1,32'h200};
      vecs[25] = '{1,0,0,9,9, 0,0,32'h0,        0,0,32'h0,   0,0,0,1,0,0,32'h0};

      idle();
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check($sformatf("r%0d rd_en", i), {31'b0, rd_en}, {31'b0, vecs[i].e_en});
         if (vecs[i].e_en) begin
            check($sformatf("r%0d rd_addr", i), {27'b0, rd_addr}, {27'b0, vecs[i].e_addr});
            check($sformatf("r%0d rd_data", i), rd_data, vecs[i].e_data);
         end
         check($sformatf("r%0d alu_ready", i), {31'b0, alu_ready}, {31'b0, vecs[i].e_ready});
         check($sformatf("r%0d rs1_busy", i), {31'b0, rs1_busy}, {31'b0, vecs[i].e_rs1});
         check($sformatf("r%0d rs2_busy", i), {31'b0, rs2_busy}, {31'b0, vecs[i].e_rs2});
         check($sformatf("r%0d busy", i), busy, vecs[i].e_busy);
         check($sformatf("r%0d lsu_ready", i), {31'b0, lsu_ready}, 32'h1);
      end

      // Reset mid-flight: buffer x20 and x21 behind LSU traffic, then reset.
      idle();
      lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h1;
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h20;
      @(posedge clk); #1;
      check("mid push1 alu_ready", {31'b0, alu_ready}, 32'h1);
      lsu_rd = 5'd2; lsu_data = 32'h2;
      alu_rd = 5'd21; alu_data = 32'h21;
      @(posedge clk); #1;
      check("mid push2 alu_ready", {31'b0, alu_ready}, 32'h0);
      idle();
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid reset rd_en", {31'b0, rd_en}, 32'h0);
      check("mid reset alu_ready", {31'b0, alu_ready}, 32'h1);
      check("mid reset busy", busy, 32'h0);
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check($sformatf("mid after%0d rd_en", k), {31'b0, rd_en}, 32'h0);
         check($sformatf("mid after%0d alu_ready", k), {31'b0, alu_ready}, 32'h1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_regfile_wb
